nbody_force_accum: RTL and testbench

Downstream consumer of the nbody force pipeline. It takes the per-pair acceleration terms (ax, ay; IEEE-754 double) that the pipeline emits during one j-sweep for body i. It sums them with a latency-ADD_LAT floating-point adder, using ADD_LAT interleaved partial sums followed by a tree reduction. It then presents one summed (ax, ay) per body to the velocity/position update stage.

---
 rtl/nbody_force_accum.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_nbody_force_accum.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nbody_force_accum.sv
// Per-body force accumulator: sums a sweep of (ax, ay) double terms through a
// latency-ADD_LAT pipelined FP adder using interleaved partial sums, then a tree reduction.
module nbody_force_accum #(
   parameter int ADD_LAT = 20,
   parameter int DATA_W  = 64,
   parameter int IDX_W   = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_ax,
   input  logic [DATA_W-1:0] in_ay,
   input  logic              in_last,
   input  logic [IDX_W-1:0]  in_idx,
   output logic              in_ready,
   output logic              out_valid,
   output logic [IDX_W-1:0]  out_idx,
   output logic [DATA_W-1:0] out_ax,
   output logic [DATA_W-1:0] out_ay,
   output logic              busy
);

   localparam int SW = $clog2(ADD_LAT);
   localparam int NW = $clog2(ADD_LAT + 1);
   localparam int CW = $clog2(2 * ADD_LAT + 1);

   localparam logic [1:0] ST_ACCUM  = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_REDUCE = 2'd2;
   localparam logic [1:0] ST_EMIT   = 2'd3;

   // IEEE-754 double add, round-to-nearest-even; exact cancellation gives +0.0.
   function automatic logic [63:0] fpAdd(input logic [63:0] a, input logic [63:0] b);
      logic        aNan, bNan, aInf, bInf, swap, sub, sBig, sticky, up;
      logic [62:0] magBig, magSmall;
      logic [10:0] eB, eS, diff;
      logic [52:0] mB, mS;
      logic [55:0] ext, shifted, mask, alB, alS, norm;
      logic [56:0] raw;
      logic [12:0] e;
      logic [5:0]  lz, sh;
      logic [53:0] rnd;
      logic [63:0] res;
      aNan     = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
      bNan     = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
      aInf     = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
      bInf     = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
      swap     = b[62:0] > a[62:0];
      magBig   = swap ? b[62:0] : a[62:0];
      magSmall = swap ? a[62:0] : b[62:0];
      sBig     = swap ? b[63] : a[63];
      sub      = a[63] ^ b[63];
      eB       = (magBig[62:52] == 11'd0) ? 11'd1 : magBig[62:52];
      eS       = (magSmall[62:52] == 11'd0) ? 11'd1 : magSmall[62:52];
      mB       = {magBig[62:52] != 11'd0, magBig[51:0]};
      mS       = {magSmall[62:52] != 11'd0, magSmall[51:0]};
      diff     = eB - eS;
      ext      = {mS, 3'b000};
      shifted  = '0;
      mask     = '0;
      sticky   = 1'b0;
      if (diff > 11'd55) begin
         sticky = |ext;
      end else begin
         shifted = ext >> diff;
         mask    = (56'd1 << diff) - 56'd1;
         sticky  = |(ext & mask);
      end
      alS  = {shifted[55:1], shifted[0] | sticky};
      alB  = {mB, 3'b000};
      raw  = sub ? ({1'b0, alB} - {1'b0, alS}) : ({1'b0, alB} + {1'b0, alS});
      e    = {2'b00, eB};
      lz   = 6'd56;
      sh   = 6'd0;
      norm = '0;
      if (raw[56]) begin
         norm = {raw[56:2], raw[1] | raw[0]};
         e    = e + 13'd1;
      end else begin
         for (int i = 0; i < 56; i++) begin
            if (raw[i]) lz = 6'(55 - i);
         end
         sh   = ({7'd0, lz} > (e - 13'd1)) ? 6'(e - 13'd1) : lz;
         norm = raw[55:0] << sh;
         e    = e - {7'd0, sh};
      end
      up  = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd = {1'b0, norm[55:3]} + 54'(up);
      if (rnd[53]) begin
         rnd = rnd >> 1;
         e   = e + 13'd1;
      end
      if (aNan)                      res = a | 64'h0008_0000_0000_0000;
      else if (bNan)                 res = b | 64'h0008_0000_0000_0000;
      else if (aInf && bInf && sub)  res = 64'h7FF8_0000_0000_0000;
      else if (aInf)                 res = a;
      else if (bInf)                 res = b;
      else if (raw == 57'd0)         res = {sub ? 1'b0 : sBig, 63'd0};
      else if (e >= 13'd2047)        res = {sBig, 11'h7FF, 52'd0};
      else                           res = {sBig, rnd[52] ? e[10:0] : 11'd0, rnd[51:0]};
      return res;
   endfunction

   logic [1:0]          state_q, state_d;
   logic [SW-1:0]       slot_q, slot_d, slotNext;
   logic [CW-1:0]       cycCnt_q, cycCnt_d;
   logic [NW-1:0]       lvlN_q, lvlN_d, half, ceilN;
   logic [ADD_LAT-1:0]  flag_q, flag_d;
   logic [IDX_W-1:0]    idx_q, idx_d, outIdx_q, outIdx_d;
   logic                outValid_q, outValid_d;
   logic [DATA_W-1:0]   outAx_q, outAx_d, outAy_q, outAy_d;
   logic [DATA_W-1:0]   pipeX_q [ADD_LAT];
   logic [DATA_W-1:0]   pipeY_q [ADD_LAT];
   logic [DATA_W-1:0]   pX_q [ADD_LAT];
   logic [DATA_W-1:0]   pY_q [ADD_LAT];
   logic [DATA_W-1:0]   fbX, fbY, opAX, opBX, opAY, opBY, sumX, sumY;
   logic                accept, inPair, wbActive, lvlEnd;
   logic [SW-1:0]       pairLo, pairHi, wbIdx, oddSrc, oddDst;

   assign in_ready  = (state_q == ST_ACCUM);
   assign busy      = (state_q != ST_ACCUM);
   assign out_valid = outValid_q;
   assign out_idx   = outIdx_q;
   assign out_ax    = outAx_q;
   assign out_ay    = outAy_q;

   assign accept   = in_valid && in_ready;
   assign slotNext = (slot_q == SW'(ADD_LAT - 1)) ? '0 : slot_q + SW'(1);
   assign fbX      = flag_q[slot_q] ? pipeX_q[ADD_LAT-1] : '0;
   assign fbY      = flag_q[slot_q] ? pipeY_q[ADD_LAT-1] : '0;

   // Each tree level issues pairs in cycles [0, half) and collects results in [ADD_LAT, ADD_LAT+half).
   assign half     = lvlN_q >> 1;
   assign ceilN    = lvlN_q - half;
   assign inPair   = (state_q == ST_REDUCE) && (cycCnt_q < CW'(half));
   assign wbActive = (state_q == ST_REDUCE) && (cycCnt_q >= CW'(ADD_LAT))
                     && (cycCnt_q < CW'(ADD_LAT) + CW'(half));
   assign lvlEnd   = (state_q == ST_REDUCE) && (cycCnt_q == CW'(ADD_LAT - 1) + CW'(half));
   assign pairLo   = SW'({cycCnt_q, 1'b0});
   assign pairHi   = {pairLo[SW-1:1], 1'b1};
   assign wbIdx    = SW'(cycCnt_q - CW'(ADD_LAT));
   assign oddSrc   = SW'(lvlN_q - NW'(1));
   assign oddDst   = SW'(half);

   always_comb begin
      opAX = '0;
      opBX = '0;
      opAY = '0;
      opBY = '0;
      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               opAX = in_ax;
               opAY = in_ay;
            end
            opBX = fbX;
            opBY = fbY;
         end
         ST_DRAIN: begin
            opBX = fbX;
            opBY = fbY;
         end
         ST_REDUCE: begin
            if (inPair) begin
               opAX = pX_q[pairLo];
               opBX = pX_q[pairHi];
               opAY = pY_q[pairLo];
               opBY = pY_q[pairHi];
            end
         end
         default: ;
      endcase
   end

   assign sumX = fpAdd(opAX, opBX);
   assign sumY = fpAdd(opAY, opBY);

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      cycCnt_d   = cycCnt_q;
      lvlN_d     = lvlN_q;
      flag_d     = flag_q;
      idx_d      = idx_q;
      outValid_d = 1'b0;
      outIdx_d   = outIdx_q;
      outAx_d    = outAx_q;
      outAy_d    = outAy_q;
      case (state_q)
         ST_ACCUM: begin
            slot_d         = slotNext;
            flag_d[slot_q] = 1'b1;
            if (accept && in_last) begin
               idx_d    = in_idx;
               cycCnt_d = '0;
               state_d  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            slot_d   = slotNext;
            cycCnt_d = cycCnt_q + CW'(1);
            if (cycCnt_q == CW'(ADD_LAT - 1)) begin
               cycCnt_d = '0;
               lvlN_d   = NW'(ADD_LAT);
               state_d  = ST_REDUCE;
            end
         end
         ST_REDUCE: begin
            cycCnt_d = cycCnt_q + CW'(1);
            if (lvlEnd) begin
               cycCnt_d = '0;
               lvlN_d   = ceilN;
               if (ceilN == NW'(1)) state_d = ST_EMIT;
            end
         end
         default: begin
            outValid_d = 1'b1;
            outIdx_d   = idx_q;
            outAx_d    = pX_q[0];
            outAy_d    = pY_q[0];
            flag_d     = '0;
            state_d    = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ACCUM;
         slot_q     <= '0;
         cycCnt_q   <= '0;
         lvlN_q     <= '0;
         flag_q     <= '0;
         idx_q      <= '0;
         outValid_q <= 1'b0;
         outIdx_q   <= '0;
         outAx_q    <= '0;
         outAy_q    <= '0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         cycCnt_q   <= cycCnt_d;
         lvlN_q     <= lvlN_d;
         flag_q     <= flag_d;
         idx_q      <= idx_d;
         outValid_q <= outValid_d;
         outIdx_q   <= outIdx_d;
         outAx_q    <= outAx_d;
         outAy_q    <= outAy_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ADD_LAT; i++) begin
            pipeX_q[i] <= '0;
            pipeY_q[i] <= '0;
         end
      end else begin
         pipeX_q[0] <= sumX;
         pipeY_q[0] <= sumY;
         for (int i = 1; i < ADD_LAT; i++) begin
            pipeX_q[i] <= pipeX_q[i-1];
            pipeY_q[i] <= pipeY_q[i-1];
         end
      end
   end

   // An odd leftover slides down to index half at the level's last cycle, beside the final writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ADD_LAT; i++) begin
            pX_q[i] <= '0;
            pY_q[i] <= '0;
         end
      end else begin
         if (state_q == ST_DRAIN) begin
            pX_q[slot_q] <= fbX;
            pY_q[slot_q] <= fbY;
         end
         if (wbActive) begin
            pX_q[wbIdx] <= pipeX_q[ADD_LAT-1];
            pY_q[wbIdx] <= pipeY_q[ADD_LAT-1];
         end
         if (lvlEnd && lvlN_q[0]) begin
            pX_q[oddDst] <= pX_q[oddSrc];
            pY_q[oddDst] <= pY_q[oddSrc];
         end
      end
   end

endmodule

// File: tb/tb_nbody_force_accum.sv
// Directed bench for nbody_force_accum: hand-computed sums, fixed 140-edge latency,
// sweep isolation and abandonment of a sweep by reset mid-reduction.
module tb_nbody_force_accum;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_ax;
   logic [63:0] in_ay;
   logic        in_last;
   logic [8:0]  in_idx;
   logic        in_ready;
   logic        out_valid;
   logic [8:0]  out_idx;
   logic [63:0] out_ax;
   logic [63:0] out_ay;
   logic        busy;

   int  checkCount;
   int  errCount;
   real tAx [64];
   real tAy [64];
   int  tGap [64];

   nbody_force_accum dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ax     (in_ax),
      .in_ay     (in_ay),
      .in_last   (in_last),
      .in_idx    (in_idx),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_ax    (out_ax),
      .out_ay    (out_ay),
      .busy      (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Presents n beats from tAx/tAy/tGap; only the last beat carries the real index.
   task automatic applyStimulus(input int n, input logic [8:0] idx);
      int waitCyc;
      waitCyc = 0;
      while (!in_ready && waitCyc < 400) begin
         @(posedge clk);
         #1;
         waitCyc++;
      end
      for (int k = 0; k < n; k++) begin
         for (int g = 0; g < tGap[k]; g++) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_ax    = $realtobits(tAx[k]);
         in_ay    = $realtobits(tAy[k]);
         in_last  = (k == n - 1);
         in_idx   = (k == n - 1) ? idx : 9'h1AA;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_ax    = '0;
      in_ay    = '0;
   endtask

   // Waits for the result strobe after the last beat and checks latency, stall and payload.
   task automatic waitResult(input string tag, input real expAx, input real expAy, input logic [8:0] expIdx);
      int  lat;
      logic seen;
      logic readyLow;
      lat      = 0;
      seen     = 1'b0;
      readyLow = 1'b1;
      for (int k = 1; k <= 200 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            seen = 1'b1;
            lat  = k;
         end else if (in_ready) begin
            readyLow = 1'b0;
         end
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'd140);
      checkOutput({tag, "_readyLow"}, 64'(readyLow), 64'd1);
      checkOutput({tag, "_ax"}, out_ax, $realtobits(expAx));
      checkOutput({tag, "_ay"}, out_ay, $realtobits(expAy));
      checkOutput({tag, "_idx"}, 64'(out_idx), 64'(expIdx));
      @(posedge clk);
      #1;
      checkOutput({tag, "_strobeOneCycle"}, 64'(out_valid), 64'd0);
      checkOutput({tag, "_axHeld"}, out_ax, $realtobits(expAx));
   endtask

   initial begin
      logic sawValid;
      checkCount = 0;
      errCount   = 0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_ax      = '0;
      in_ay      = '0;
      in_last    = 1'b0;
      in_idx     = '0;
      for (int i = 0; i < 64; i++) tGap[i] = 0;

      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_outValid", 64'(out_valid), 64'd0);
      checkOutput("rst_outAx", out_ax, 64'd0);
      checkOutput("rst_outAy", out_ay, 64'd0);
      checkOutput("rst_outIdx", 64'(out_idx), 64'd0);
      checkOutput("rst_inReady", 64'(in_ready), 64'd1);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] three-term sweep");
      tAx[0] = 1.0;  tAx[1] = 2.0;  tAx[2] = 3.0;
      tAy[0] = -1.0; tAy[1] = -2.0; tAy[2] = -3.0;
      applyStimulus(3, 9'd5);
      checkOutput("t2_busyAfterLast", 64'(busy), 64'd1);
      waitResult("t2", 6.0, -6.0, 9'd5);

      $display("[TB] 21-term sweep with gaps");
      for (int k = 0; k < 21; k++) begin
         tAx[k]  = real'(k);
         tAy[k]  = 0.5;
         tGap[k] = (k == 0) ? 0 : int'($urandom_range(0, 3));
      end
      applyStimulus(21, 9'd20);
      waitResult("t3", 210.0, 10.5, 9'd20);

      $display("[TB] 45-term sweep");
      for (int k = 0; k < 45; k++) begin
         tAx[k]  = 1.0;
         tAy[k]  = (k % 2 == 0) ? 1.0 : -1.0;
         tGap[k] = 0;
      end
      applyStimulus(45, 9'd7);
      waitResult("t4", 45.0, 1.0, 9'd7);

      $display("[TB] one-term sweep then two-term sweep");
      tAx[0] = -2.5;
      tAy[0] = 0.25;
      applyStimulus(1, 9'd0);
      waitResult("t5a", -2.5, 0.25, 9'd0);
      tAx[0] = 4.0; tAx[1] = 4.0;
      tAy[0] = 0.0; tAy[1] = 0.0;
      applyStimulus(2, 9'd1);
      waitResult("t5b", 8.0, 0.0, 9'd1);

      $display("[TB] reset during reduction");
      tAx[0] = 3.0; tAx[1] = 5.0;
      tAy[0] = 1.0; tAy[1] = 1.0;
      applyStimulus(2, 9'd9);
      repeat (49) @(posedge clk);
      #1;
      checkOutput("t6_busyInReduce", 64'(busy), 64'd1);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("t6_readyAfterRst", 64'(in_ready), 64'd1);
      checkOutput("t6_busyAfterRst", 64'(busy), 64'd0);
      sawValid = 1'b0;
      for (int k = 0; k < 160; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("t6_noEmit", 64'(sawValid), 64'd0);
      tAx[0] = 1.0; tAx[1] = 1.0;
      tAy[0] = 0.0; tAy[1] = 0.0;
      applyStimulus(2, 9'd3);
      waitResult("t6", 2.0, 0.0, 9'd3);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
